// File: rtl/dvp_pkg.sv
// ---------------------------------------------------------------------------
// Module : dvp_pkg
// Brief  : Shared types and RGB565 colour-bar constants for the DVP source.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } dvp_state_t;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } byte_phase_t;

    localparam logic [15:0] C_BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] C_BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] C_BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] C_BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] C_BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] C_BAR_RED     = 16'hF800;
    localparam logic [15:0] C_BAR_BLUE    = 16'h001F;
    localparam logic [15:0] C_BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] col;
        col = C_BAR_BLACK;
        case (idx)
            3'd0:    col = C_BAR_WHITE;
            3'd1:    col = C_BAR_YELLOW;
            3'd2:    col = C_BAR_CYAN;
            3'd3:    col = C_BAR_GREEN;
            3'd4:    col = C_BAR_MAGENTA;
            3'd5:    col = C_BAR_RED;
            3'd6:    col = C_BAR_BLUE;
            default: col = C_BAR_BLACK;
        endcase
        return col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dvp_timing_gen.sv
// ---------------------------------------------------------------------------
// Module : dvp_timing_gen
// Brief  : PCLK divider, line/frame counters and frame FSM. Counters hold the
//          position of the PCLK period emitted at the next tick edge.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dvp_timing_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_WIDTH = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    output logic        o_pclk,
    output logic        o_tick,
    output logic        o_href_next,
    output logic        o_vsync_next,
    output logic        o_busy_next,
    output logic        o_px_req,
    output logic        o_frame_start,
    output byte_phase_t o_byte_phase
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int V_MAX_A  = (VSYNC_WIDTH > V_BACK)  ? VSYNC_WIDTH : V_BACK;
    localparam int V_MAX_B  = (V_ACTIVE > V_FRONT)    ? V_ACTIVE    : V_FRONT;
    localparam int V_MAX    = (V_MAX_A > V_MAX_B)     ? V_MAX_A     : V_MAX_B;
    localparam int H_W      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int V_W      = (V_MAX > 1)    ? $clog2(V_MAX)    : 1;

    localparam logic [H_W-1:0] C_H_LAST   = H_W'(LINE_LEN - 1);
    localparam logic [31:0]    C_HREF_END = 32'(2 * H_ACTIVE);

    dvp_state_t     r_state;
    dvp_state_t     w_state_nxt;
    logic [H_W-1:0] r_h;
    logic [H_W-1:0] w_h_nxt;
    logic [V_W-1:0] r_v;
    logic [V_W-1:0] w_v_nxt;
    logic [V_W-1:0] w_v_last;
    logic           r_pclk;
    logic           w_active;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_pclk  <= 1'b0;
            r_state <= ST_IDLE;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_pclk  <= ~r_pclk;
            r_state <= w_state_nxt;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
        end
    end

    always_comb begin
        w_v_last = '0;
        case (r_state)
            ST_VSYNC:  w_v_last = V_W'(VSYNC_WIDTH - 1);
            ST_VBACK:  w_v_last = V_W'(V_BACK - 1);
            ST_ACTIVE: w_v_last = V_W'(V_ACTIVE - 1);
            ST_VFRONT: w_v_last = V_W'(V_FRONT - 1);
            default:   w_v_last = '0;
        endcase
    end

    // Everything advances once per PCLK period, on the edge that ends a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        if (r_pclk) begin
            if (r_state == ST_IDLE) begin
                if (i_enable) begin
                    w_state_nxt = ST_VSYNC;
                    w_h_nxt     = '0;
                    w_v_nxt     = '0;
                end
            end else if (r_h == C_H_LAST) begin
                w_h_nxt = '0;
                if (r_v == w_v_last) begin
                    w_v_nxt = '0;
                    case (r_state)
                        ST_VSYNC:  w_state_nxt = ST_VBACK;
                        ST_VBACK:  w_state_nxt = ST_ACTIVE;
                        ST_ACTIVE: w_state_nxt = ST_VFRONT;
                        ST_VFRONT: w_state_nxt = i_enable ? ST_VSYNC : ST_IDLE;
                        default:   w_state_nxt = ST_IDLE;
                    endcase
                end else begin
                    w_v_nxt = r_v + 1'b1;
                end
            end else begin
                w_h_nxt = r_h + 1'b1;
            end
        end
    end

    assign w_active      = (r_state == ST_ACTIVE) && (32'(r_h) < C_HREF_END);
    assign o_pclk        = r_pclk;
    assign o_tick        = r_pclk;
    assign o_href_next   = w_active;
    assign o_vsync_next  = (r_state == ST_VSYNC);
    assign o_busy_next   = (r_state != ST_IDLE);
    assign o_byte_phase  = r_h[0] ? PH_LO : PH_HI;
    assign o_px_req      = r_pclk & w_active & ~r_h[0];
    // Strobe on the tick that emits the first VSYNC period of a frame.
    assign o_frame_start = r_pclk && (r_state == ST_VSYNC) && (r_h == '0) && (r_v == '0);

endmodule

`default_nettype wire

// File: rtl/dvp_stream_tx.sv
// ---------------------------------------------------------------------------
// Module : dvp_stream_tx
// Brief  : RGB565 stream to OV-style DVP source (camera emulator).
//          Macro DVP_STREAM_TX_TESTPATTERN_EN swaps the stream for colour bars.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dvp_stream_tx
    import dvp_pkg::*;
#(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          H_BLANK     = 144,
    parameter int          VSYNC_WIDTH = 3,
    parameter int          V_BACK      = 17,
    parameter int          V_FRONT     = 10,
    parameter logic [15:0] FILL_DATA   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] px_data,
    input  logic        px_valid,
    output logic        px_ready,
    output logic        dvp_pclk,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_busy,
    output logic        underrun
);

    logic        w_tick;
    logic        w_href_next;
    logic        w_vsync_next;
    logic        w_busy_next;
    logic        w_px_req;
    logic        w_frame_start;
    byte_phase_t w_phase;
    logic [15:0] w_px_src;
    logic        w_starve;

    logic        r_vsync;
    logic        r_href;
    logic [7:0]  r_data;
    logic [7:0]  r_lo;
    logic        r_busy;
    logic        r_underrun;

    dvp_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_WIDTH (VSYNC_WIDTH),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .clk           (clk),
        .i_rst_n       (reset_n),
        .i_enable      (enable),
        .o_pclk        (dvp_pclk),
        .o_tick        (w_tick),
        .o_href_next   (w_href_next),
        .o_vsync_next  (w_vsync_next),
        .o_busy_next   (w_busy_next),
        .o_px_req      (w_px_req),
        .o_frame_start (w_frame_start),
        .o_byte_phase  (w_phase)
    );

`ifdef DVP_STREAM_TX_TESTPATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    logic [15:0] r_pat_px;
    logic [15:0] w_bar_full;
    logic [2:0]  w_bar_idx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pat_px <= '0;
        end else if (w_tick) begin
            if (!w_href_next) begin
                r_pat_px <= '0;
            end else if (w_px_req) begin
                r_pat_px <= r_pat_px + 16'd1;
            end
        end
    end

    assign w_bar_full = r_pat_px / 16'(BAR_W);
    assign w_bar_idx  = (w_bar_full > 16'd7) ? 3'd7 : w_bar_full[2:0];
    assign w_px_src   = bar_colour(w_bar_idx);
    assign w_starve   = 1'b0;
    assign px_ready   = 1'b0;
`else
    // A starved slot sends FILL_DATA and leaves the upstream pixel unconsumed.
    assign w_px_src = px_valid ? px_data : FILL_DATA;
    assign w_starve = w_px_req & ~px_valid;
    assign px_ready = w_px_req;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vsync    <= 1'b0;
            r_href     <= 1'b0;
            r_data     <= 8'h00;
            r_lo       <= 8'h00;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_tick) begin
                r_vsync <= w_vsync_next;
                r_href  <= w_href_next;
                r_busy  <= w_busy_next;
                if (!w_href_next) begin
                    r_data <= 8'h00;
                end else if (w_phase == PH_HI) begin
                    r_data <= w_px_src[15:8];
                    r_lo   <= w_px_src[7:0];
                end else begin
                    r_data <= r_lo;
                end
            end
            if (w_frame_start) begin
                r_underrun <= 1'b0;
            end else if (w_starve) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign dvp_vsync  = r_vsync;
    assign dvp_href   = r_href;
    assign dvp_data   = r_data;
    assign frame_busy = r_busy;
    assign underrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_dvp_stream_tx.sv
// ---------------------------------------------------------------------------
// Module : tb_dvp_stream_tx
// Brief  : Scoreboard bench for dvp_stream_tx with a 4x2 pixel frame.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dvp_stream_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] px_data;
    logic        px_valid;
    logic        px_ready;
    logic        dvp_pclk;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;
    logic        frame_busy;
    logic        underrun;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] pix_tab[8] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718,
                                16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90};
    int          pix_k      = 0;
    int          frame_req  = 0;
    int          frame_hs   = 0;
    int          starve_idx = -1;

    always #5 clk = ~clk;

    dvp_stream_tx #(
        .H_ACTIVE    (4),
        .V_ACTIVE    (2),
        .H_BLANK     (3),
        .VSYNC_WIDTH (1),
        .V_BACK      (1),
        .V_FRONT     (1),
        .FILL_DATA   (16'h0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .dvp_pclk   (dvp_pclk),
        .dvp_vsync  (dvp_vsync),
        .dvp_href   (dvp_href),
        .dvp_data   (dvp_data),
        .frame_busy (frame_busy),
        .underrun   (underrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pclk"},     32'(dvp_pclk),   32'd0);
        chk({tag, "_vsync"},    32'(dvp_vsync),  32'd0);
        chk({tag, "_href"},     32'(dvp_href),   32'd0);
        chk({tag, "_data"},     32'(dvp_data),   32'd0);
        chk({tag, "_busy"},     32'(frame_busy), 32'd0);
        chk({tag, "_underrun"}, 32'(underrun),   32'd0);
        chk({tag, "_px_ready"}, 32'(px_ready),   32'd0);
    endtask

    // Source driver: pushes expected bytes whenever the DUT takes a slot.
    initial begin
        px_valid = 1'b0;
        px_data  = 16'h0000;
        forever begin
            @(negedge clk);
            px_valid = (frame_req != starve_idx);
            px_data  = pix_tab[pix_k % 8];
            #1;
            if (px_ready) begin
                if (px_valid) begin
                    exp_q.push_back(px_data[15:8]);
                    exp_q.push_back(px_data[7:0]);
                    pix_k++;
                    frame_hs++;
                end else begin
                    exp_q.push_back(8'h00);
                    exp_q.push_back(8'h00);
                end
                frame_req++;
            end
        end
    end

    // Monitor: captures dvp_data on every PCLK rise.
    initial begin
        forever begin
            @(posedge dvp_pclk);
            #1;
            if (dvp_href) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL data_byte: got %02h with no expected byte queued", dvp_data);
                end else begin
                    chk("data_byte", 32'(dvp_data), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("data_blank_zero", 32'(dvp_data), 32'd0);
            end
        end
    end

    task automatic next_rise();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (dvp_pclk) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL pclk_rise: got none expected one within 4 clk");
    endtask

    task automatic wait_vsync(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            if (dvp_pclk && dvp_vsync) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL vsync_start: got no VSYNC expected one within 800 clk");
        end
    endtask

    // Period p of a 55-period frame: line p/11, column p%11.
    task automatic check_frame(input bit drop, input int starve, input bit ur_end);
        bit ok;
        int line;
        int col;
        starve_idx = starve;
        wait_vsync(ok);
        if (!ok) return;
        frame_req = 0;
        frame_hs  = 0;
        for (int p = 0; p < 55; p++) begin
            if (p > 0) next_rise();
            line = p / 11;
            col  = p % 11;
            chk("vsync", 32'(dvp_vsync), 32'(line == 0));
            chk("href", 32'(dvp_href), 32'((line == 2 || line == 3) && col < 8));
            chk("frame_busy", 32'(frame_busy), 32'd1);
            if (p == 0) chk("underrun_at_vsync", 32'(underrun), 32'd0);
            if (drop && p == 25) enable = 1'b0;
        end
        chk("underrun_frame_end", 32'(underrun), 32'(ur_end));
        chk("handshakes", 32'(frame_hs), (starve >= 0) ? 32'd7 : 32'd8);
        chk("requests", 32'(frame_req), 32'd8);
        starve_idx = -1;
    endtask

    task automatic check_idle_after();
        logic any_vs;
        next_rise();
        chk("busy_after_frame", 32'(frame_busy), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        any_vs = 1'b0;
        for (int i = 0; i < 30; i++) begin
            next_rise();
            any_vs = any_vs | dvp_vsync | frame_busy;
        end
        chk("no_new_frame", 32'(any_vs), 32'd0);
    endtask

    initial begin
        int   rises;
        logic quiet;
        bit   ok;
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_all_zero("reset");

        @(negedge clk);
        reset_n = 1'b1;
        rises   = 0;
        quiet   = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (dvp_pclk) rises++;
            quiet = quiet | dvp_vsync | frame_busy | dvp_href;
        end
        chk("idle_pclk_rises", 32'(rises), 32'd10);
        chk("idle_quiet", 32'(quiet), 32'd0);

        // Frame A, enable dropped mid-ACTIVE.
        @(negedge clk);
        enable = 1'b1;
        check_frame(1'b1, -1, 1'b0);
        check_idle_after();

        // Frame B starves its third pixel, frame C follows back-to-back.
        @(negedge clk);
        enable = 1'b1;
        check_frame(1'b0, 2, 1'b1);
        check_frame(1'b1, -1, 1'b0);
        check_idle_after();

        // Reset while HREF is high, then a clean frame.
        @(negedge clk);
        enable = 1'b1;
        wait_vsync(ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (dvp_href) begin
                ok = 1'b1;
                break;
            end
        end
        chk("href_seen_before_reset", 32'(ok), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("midframe_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_frame(1'b1, -1, 1'b0);
        check_idle_after();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected one before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
